// File: rtl/multiplexer_4to1.sv
// Registered 4-to-1 selector with a valid flag and an asynchronous active-low reset.
// Optional even-parity output is enabled by defining MULTIPLEXER_PARITY_EN.
module multiplexer_4to1 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] a2,
   input  logic [WIDTH-1:0] a3,
   input  logic [WIDTH-1:0] a4,
   input  logic [1:0]       sel,
   input  logic             in_valid,
   output logic [WIDTH-1:0] signal,
`ifdef MULTIPLEXER_PARITY_EN
   output logic             out_parity,
`endif
   output logic             out_valid
);

   logic [WIDTH-1:0] w_selected;
   logic [WIDTH-1:0] r_signal;
   logic             r_valid;

   // The zero default keeps an unknown select from leaking X into the data register.
   always_comb begin
      w_selected = '0;
      case (sel)
         2'b00: w_selected = a1;
         2'b01: w_selected = a2;
         2'b10: w_selected = a3;
         2'b11: w_selected = a4;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_signal <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_signal <= w_selected;
         end
      end
   end

   assign signal    = r_signal;
   assign out_valid = r_valid;

`ifdef MULTIPLEXER_PARITY_EN
   logic r_parity;

   // Parity is computed from the selected input so it lands on the same edge as the data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_parity <= 1'b0;
      end else if (in_valid) begin
         r_parity <= ^w_selected;
      end
   end

   assign out_parity = r_parity;
`endif

endmodule

// File: tb/tb_multiplexer_4to1.sv
// Self-checking bench for multiplexer_4to1: a 1-bit and an 8-bit instance share control inputs.
// Parity checks run only when MULTIPLEXER_PARITY_EN is defined.
module tb_multiplexer_4to1;

   typedef struct packed {
      logic       s1;
      logic [7:0] s8;
      logic       p;
      logic       v;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [1:0] sel;
   logic       inValid;
   logic       a1w1, a2w1, a3w1, a4w1;
   logic [7:0] a1w8, a2w8, a3w8, a4w8;
   logic       signal1, valid1;
   logic [7:0] signal8;
   logic       valid8;
   logic       par1, par8;

   logic       mSig1, mPar, mValid;
   logic [7:0] mSig8;
   exp_t       sbq[$];
   int         nCompared;
   int         nMismatched;

   multiplexer_4to1 #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .a1(a1w1), .a2(a2w1), .a3(a3w1), .a4(a4w1),
      .sel(sel), .in_valid(inValid),
      .signal(signal1),
`ifdef MULTIPLEXER_PARITY_EN
      .out_parity(par1),
`endif
      .out_valid(valid1)
   );

   multiplexer_4to1 #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .a1(a1w8), .a2(a2w8), .a3(a3w8), .a4(a4w8),
      .sel(sel), .in_valid(inValid),
      .signal(signal8),
`ifdef MULTIPLEXER_PARITY_EN
      .out_parity(par8),
`endif
      .out_valid(valid8)
   );

`ifndef MULTIPLEXER_PARITY_EN
   assign par1 = 1'b0;
   assign par8 = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pick the expected source, push the expectation, then advance one edge.
   task automatic applyStimulus();
      exp_t e;
      if (rst_n && inValid) begin
         case (sel)
            2'b00: begin mSig1 = a1w1; mSig8 = a1w8; end
            2'b01: begin mSig1 = a2w1; mSig8 = a2w8; end
            2'b10: begin mSig1 = a3w1; mSig8 = a3w8; end
            default: begin mSig1 = a4w1; mSig8 = a4w8; end
         endcase
         mPar = ^mSig8;
      end
      mValid = rst_n && inValid;
      if (!rst_n) begin
         mSig1 = 1'b0; mSig8 = 8'h00; mPar = 1'b0;
      end
      e.s1 = mSig1; e.s8 = mSig8; e.p = mPar; e.v = mValid;
      sbq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      rst_n = 1'b0; inValid = 1'b1; sel = 2'b10;
      a1w1 = 1'b1; a2w1 = 1'b1; a3w1 = 1'b1; a4w1 = 1'b1;
      a1w8 = 8'h5A; a2w8 = 8'hC3; a3w8 = 8'hFF; a4w8 = 8'h81;
      mSig1 = 1'b0; mSig8 = 8'h00; mPar = 1'b0; mValid = 1'b0;
      #2;
      nCompared++;
      if (signal8 !== 8'h00 || valid8 !== 1'b0 || signal1 !== 1'b0 || valid1 !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_immediate: got sig8=%h v8=%b sig1=%b v1=%b want 00/0/0/0",
                  signal8, valid8, signal1, valid1);
      end
`ifdef MULTIPLEXER_PARITY_EN
      nCompared++;
      if (par8 !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_parity: got %b want 0", par8);
      end
`endif
      applyStimulus();
      e = sbq.pop_front();
      nCompared++;
      if (signal8 !== e.s8 || valid8 !== e.v || signal1 !== e.s1) begin
         nMismatched++;
         $display("[TB] FAIL reset_capture_ignored: got sig8=%h v=%b sig1=%b want %h/%b/%b",
                  signal8, valid8, signal1, e.s8, e.v, e.s1);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_exhaustive_select();
      exp_t e;
      a1w1 = 1'b1; a2w1 = 1'b0; a3w1 = 1'b1; a4w1 = 1'b0;
      a1w8 = 8'hA5; a2w8 = 8'h3C; a3w8 = 8'hFF; a4w8 = 8'h00;
      inValid = 1'b1;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         applyStimulus();
         e = sbq.pop_front();
         nCompared++;
         if (signal1 !== e.s1 || valid1 !== e.v) begin
            nMismatched++;
            $display("[TB] FAIL select_w1 sel=%0d: got sig=%b v=%b want %b/%b", s, signal1, valid1, e.s1, e.v);
         end
         nCompared++;
         if (signal8 !== e.s8 || valid8 !== e.v) begin
            nMismatched++;
            $display("[TB] FAIL select_w8 sel=%0d: got sig=%h v=%b want %h/%b", s, signal8, valid8, e.s8, e.v);
         end
      end
   endtask

   task automatic test_hold();
      exp_t e;
      a1w1 = 1'b1; a2w1 = 1'b0;
      sel = 2'b00; inValid = 1'b1;
      applyStimulus();
      e = sbq.pop_front();
      nCompared++;
      if (signal1 !== 1'b1 || signal1 !== e.s1 || valid1 !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL hold_capture: got sig=%b v=%b want 1/1", signal1, valid1);
      end
      // Mid-cycle input changes must not reach the registered outputs.
      #2;
      sel = 2'b01; a1w8 = ~a1w8; a2w8 = 8'h11;
      #1;
      nCompared++;
      if (signal1 !== 1'b1 || signal8 !== e.s8 || valid8 !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL no_comb_path: got sig1=%b sig8=%h v=%b want 1/%h/1", signal1, signal8, valid8, e.s8);
      end
      inValid = 1'b0;
      applyStimulus();
      e = sbq.pop_front();
      nCompared++;
      if (signal1 !== 1'b1 || valid1 !== 1'b0 || signal8 !== e.s8 || valid8 !== e.v) begin
         nMismatched++;
         $display("[TB] FAIL hold_idle: got sig1=%b v1=%b sig8=%h v8=%b want 1/0/%h/%b",
                  signal1, valid1, signal8, valid8, e.s8, e.v);
      end
   endtask

   task automatic test_wide();
      exp_t e;
      a1w8 = 8'hA5; a2w8 = 8'h3C; a3w8 = 8'hFF; a4w8 = 8'h00;
      sel = 2'b10; inValid = 1'b1;
      applyStimulus();
      e = sbq.pop_front();
      nCompared++;
      if (signal8 !== 8'hFF || signal8 !== e.s8 || valid8 !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL wide_sel10: got sig=%h v=%b want ff/1", signal8, valid8);
      end
   endtask

   task automatic test_parity();
      exp_t e;
      a2w8 = 8'h07; sel = 2'b01; inValid = 1'b1;
      applyStimulus();
      e = sbq.pop_front();
      nCompared++;
      if (signal8 !== 8'h07 || signal8 !== e.s8) begin
         nMismatched++;
         $display("[TB] FAIL parity_data: got %h want 07", signal8);
      end
`ifdef MULTIPLEXER_PARITY_EN
      nCompared++;
      if (par8 !== 1'b1 || par8 !== e.p) begin
         nMismatched++;
         $display("[TB] FAIL parity_bit: got %b want 1", par8);
      end
      inValid = 1'b0; a2w8 = 8'h03;
      applyStimulus();
      e = sbq.pop_front();
      nCompared++;
      if (par8 !== e.p) begin
         nMismatched++;
         $display("[TB] FAIL parity_hold: got %b want %b", par8, e.p);
      end
`endif
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int i = 0; i < 24; i++) begin
         sel = 2'($urandom_range(0, 3));
         inValid = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
         a1w1 = 1'($urandom); a2w1 = 1'($urandom); a3w1 = 1'($urandom); a4w1 = 1'($urandom);
         a1w8 = 8'($urandom); a2w8 = 8'($urandom); a3w8 = 8'($urandom); a4w8 = 8'($urandom);
         applyStimulus();
         e = sbq.pop_front();
         nCompared++;
         if (signal8 !== e.s8 || valid8 !== e.v || signal1 !== e.s1 || valid1 !== e.v) begin
            nMismatched++;
            $display("[TB] FAIL b2b[%0d]: got sig8=%h v8=%b sig1=%b v1=%b want %h/%b/%b",
                     i, signal8, valid8, signal1, valid1, e.s8, e.v, e.s1);
         end
`ifdef MULTIPLEXER_PARITY_EN
         nCompared++;
         if (par8 !== e.p) begin
            nMismatched++;
            $display("[TB] FAIL b2b_parity[%0d]: got %b want %b", i, par8, e.p);
         end
`endif
      end
   endtask

   task automatic test_reset_midstream();
      exp_t e;
      sel = 2'b01; inValid = 1'b1; a2w8 = 8'hE7; a2w1 = 1'b1;
      applyStimulus();
      e = sbq.pop_front();
      nCompared++;
      if (valid8 !== 1'b1 || signal8 !== e.s8) begin
         nMismatched++;
         $display("[TB] FAIL midstream_pre: got sig=%h v=%b want %h/1", signal8, valid8, e.s8);
      end
      #3;
      rst_n = 1'b0;
      mSig1 = 1'b0; mSig8 = 8'h00; mPar = 1'b0; mValid = 1'b0;
      #1;
      nCompared++;
      if (signal8 !== 8'h00 || valid8 !== 1'b0 || signal1 !== 1'b0 || valid1 !== 1'b0 || par8 !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL midstream_async_clear: got sig8=%h v8=%b sig1=%b v1=%b p=%b want 00/0/0/0/0",
                  signal8, valid8, signal1, valid1, par8);
      end
      applyStimulus();
      e = sbq.pop_front();
      nCompared++;
      if (signal8 !== e.s8 || valid8 !== e.v) begin
         nMismatched++;
         $display("[TB] FAIL midstream_discard: got sig=%h v=%b want %h/%b", signal8, valid8, e.s8, e.v);
      end
      rst_n = 1'b1;
      sel = 2'b11; a4w8 = 8'h96; a4w1 = 1'b1;
      applyStimulus();
      e = sbq.pop_front();
      nCompared++;
      if (signal8 !== 8'h96 || signal8 !== e.s8 || valid8 !== 1'b1 || signal1 !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL midstream_first_capture: got sig8=%h v=%b sig1=%b want 96/1/1",
                  signal8, valid8, signal1);
      end
   endtask

   initial begin
      nCompared = 0;
      nMismatched = 0;
      test_reset();
      test_exhaustive_select();
      test_hold();
      test_wide();
      test_parity();
      test_back_to_back();
      test_reset_midstream();
      nCompared++;
      if (sbq.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries left want 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/multiplexer_4to1.md
# multiplexer_4to1

Registered 4-to-1 selector: one of four equal-width data inputs is chosen by a 2-bit select, captured on the clock edge and presented on `signal` with a valid flag. It is the generic data-path steering element used wherever a small set of sources drives one downstream consumer, and it gives a clean registered boundary between them.

## Interface
- `WIDTH`, default 1: bit width of each data input and of `signal`; legal range 1..64.
- `clk`  input  1  rising-edge clock for all state.
- `rst_n`  input  1  asynchronous, active-low reset.
- `a1`  input  WIDTH  data source 0, selected by `sel` = 2'b00.
- `a2`  input  WIDTH  data source 1, selected by `sel` = 2'b01.
- `a3`  input  WIDTH  data source 2, selected by `sel` = 2'b10.
- `a4`  input  WIDTH  data source 3, selected by `sel` = 2'b11.
- `sel`  input  2  source select, sampled on the same edge as the data.
- `in_valid`  input  1  capture enable; high means update the output register on this edge.
- `signal`  output  WIDTH  registered selected data.
- `out_valid`  output  1  high for exactly the cycle after an accepted capture.
- `out_parity`  output  1  even parity of `signal`; present only with MULTIPLEXER_PARITY_EN.

## Operation
- Select mapping is fixed: 00 picks `a1`, 01 picks `a2`, 10 picks `a3`, 11 picks `a4`. All four codes are legal, and there is no default or illegal case.
- On a rising `clk` edge with `in_valid`=1, `signal` loads the selected input and `out_valid` is set to 1.
- On a rising edge with `in_valid`=0, `signal` holds its previous value and `out_valid` is cleared to 0.
- An X or Z on `sel` must not be propagated into `signal` during synthesis-equivalent simulation. Implement the selection with a full case statement covering all four codes.
- When `rst_n` is asserted (low), `signal`=0, `out_valid`=0 and `out_parity`=0 immediately, without waiting for a clock.
- While `rst_n` is low, the block ignores captures. The first capture is accepted on the first rising edge after `rst_n` deasserts with `in_valid`=1.
- There is no backpressure. Every capture overwrites the previous one, and the consumer is responsible for sampling `signal` when `out_valid`=1.

## Timing
- Latency: 1 cycle from the sampling edge of `sel`/data to `signal` and `out_valid`.
- Throughput: one selection per cycle. Back-to-back `in_valid` keeps `out_valid` high continuously while `signal` changes every cycle.
- A change on `sel` or on the data inputs between edges has no effect on the outputs. The outputs are purely registered, with no combinational path from any input to any output.
- Reset asserted mid-stream clears the outputs asynchronously. A capture on the same edge where `rst_n` is still low is discarded.
- Reset deassertion is expected to be synchronized externally to `clk`.

## Configuration
- `MULTIPLEXER_PARITY_EN` defined:
  - Adds the `out_parity` port, driven from a register as the XOR-reduce of the selected input.
  - It updates on the same edge as `signal`, has the same 1-cycle latency, resets to 0 and holds when `in_valid`=0.
- `MULTIPLEXER_PARITY_EN` not defined:
  - The `out_parity` port and its register do not exist.
  - All other behaviour is identical.

## Test plan
- Reset check: with `rst_n`=0 and arbitrary inputs, `signal`=0 and `out_valid`=0 must hold immediately, with no clock edge required.
- Exhaustive select, WIDTH=1: set a1=1, a2=0, a3=1, a4=0, `in_valid`=1, and step `sel` through 00, 01, 10, 11 on successive edges. `signal` one cycle later must read 1, 0, 1, 0.
- Hold: after a capture of `sel`=00 giving `signal`=1, drop `in_valid` and change `sel` to 01. `signal` must stay 1, and `out_valid` must go 0 the next cycle.
- Wide data, WIDTH=8: a1=8'hA5, a2=8'h3C, a3=8'hFF, a4=8'h00, with `sel`=10 captured. `signal` must read 8'hFF and `out_valid` must be 1.
- Reset mid-stream: pull `rst_n` low between edges while `out_valid`=1. The outputs must clear at once, and after release the first `in_valid` edge with `sel`=11 must give `signal`=a4.
- Parity, with MULTIPLEXER_PARITY_EN and WIDTH=8: capture a2=8'h07. `out_parity` must be 1 on the same cycle that `signal`=8'h07.
